// File: rtl/id_decode_queue.sv
// DEPTH-entry IF->ID instruction queue with full RV32I field decode of the head entry.
// Decode is purely combinational from the head slot; all decode outputs read zero when empty.
module id_decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [XLEN-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [6:0]               op,
    output logic [2:0]               funct3,
    output logic [6:0]               funct7,
    output logic [4:0]               rs1,
    output logic [4:0]               rs2,
    output logic [4:0]               rd,
    output logic [XLEN-1:0]          imm,
    output logic [2:0]               imm_fmt,
    output logic                     illegal,
    output logic [XLEN-1:0]          pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = DEPTH;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            push, pop;
    entry_t          head;
    logic [31:0]     ins;
    fmt_e            fmt;
    logic signed [31:0] imm32;

    assign in_ready  = (count != CNT_FULL);
    assign out_valid = (count != '0);
    // Flush swallows any handshake that happens in the same cycle.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{instr: in_instr, pc: in_pc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];
    assign ins  = head.instr;

    always_comb begin
        op      = '0;
        funct3  = '0;
        funct7  = '0;
        rs1     = '0;
        rs2     = '0;
        rd      = '0;
        pc      = '0;
        fmt     = FMT_R;
        imm32   = '0;
        illegal = 1'b0;
        if (out_valid) begin
            op     = ins[6:0];
            funct3 = ins[14:12];
            funct7 = ins[31:25];
            rs1    = ins[19:15];
            rs2    = ins[24:20];
            rd     = ins[11:7];
            pc     = head.pc;
            // Any opcode with [1:0] != 2'b11 lands in the default arm.
            case (ins[6:0])
                7'b0110011: fmt = FMT_R;
                7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
                    fmt   = FMT_I;
                    rs2   = '0;
                    imm32 = {{20{ins[31]}}, ins[31:20]};
                end
                7'b0100011: begin
                    fmt   = FMT_S;
                    rd    = '0;
                    imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                end
                7'b1100011: begin
                    fmt   = FMT_B;
                    rd    = '0;
                    imm32 = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
                end
                7'b0110111, 7'b0010111: begin
                    fmt   = FMT_U;
                    rs1   = '0;
                    rs2   = '0;
                    imm32 = {ins[31:12], 12'b0};
                end
                7'b1101111: begin
                    fmt   = FMT_J;
                    rs1   = '0;
                    rs2   = '0;
                    imm32 = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
                end
                default: illegal = 1'b1;
            endcase
        end
    end

    // Signed cast sign-extends the 32-bit immediate when XLEN is 64.
    assign imm     = XLEN'(imm32);
    assign imm_fmt = fmt;

endmodule
